fft_frame_sequencer: RTL and testbench

- Sequences one FFT frame at a time between the 12-bit sample stream, the FFT core and the FT245 transmit FIFO.
- Frame cycle:
  - Capture N_FFT consecutive valid samples into the frame buffer.
  - Pulse the FFT start input.
  - Wait for the FFT done pulse.
  - Stream a header plus N_FFT/2 magnitude bins, as bytes, into the TX FIFO. The FT clock-domain writer drains that FIFO.
- Sits in System_Top_noXADC between the sample input/XADC path, the FFT core and the FT245 interface. Runs on sysCLK only.

---
 rtl/fft_frame_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
// -----------------------------------------------------------------------------
// fft_frame_sequencer
//
// Runs one FFT frame at a time: captures N_FFT valid samples into the frame
// buffer, kicks the FFT core, waits for it to finish, then streams a two-byte
// header (sync byte + frame number) followed by N_FFT/2 result words (MSB byte
// first) into the TX FIFO feeding the FT245 writer. Single clock (sysCLK).
//
// Ports
//   sysCLK, rst          clock, asynchronous active-high reset
//   enable_sw            asynchronous run switch, 2-FF synchronized internally
//   data, data_valid     12-bit signed sample stream
//   buf_we/waddr/wdata   frame buffer write port (registered)
//   fft_start, fft_done  FFT core handshake (one-cycle pulses)
//   res_raddr, res_rdata result RAM read port, 1-cycle read latency
//   tx_data, tx_wr       byte push into TX FIFO, gated by tx_full
//   frame_cnt            completed-frame counter (wraps)
//   overrun, fft_err     sticky status flags, cleared only by rst
// -----------------------------------------------------------------------------
module fft_frame_sequencer #(
    parameter int          N_FFT       = 1024,
    parameter int          LOG2N       = 10,
    parameter int          RES_W       = 16,
    parameter int          FFT_TIMEOUT = 65535,
    parameter logic [7:0]  HDR_BYTE    = 8'hA5
) (
    input  logic               sysCLK,
    input  logic               rst,
    input  logic               enable_sw,
    input  logic [11:0]        data,
    input  logic               data_valid,
    output logic               buf_we,
    output logic [LOG2N-1:0]   buf_waddr,
    output logic [11:0]        buf_wdata,
    output logic               fft_start,
    input  logic               fft_done,
    output logic [LOG2N-2:0]   res_raddr,
    input  logic [RES_W-1:0]   res_rdata,
    output logic [7:0]         tx_data,
    output logic               tx_wr,
    input  logic               tx_full,
    output logic [7:0]         frame_cnt,
    output logic               overrun,
    output logic               fft_err
);

    localparam int CNT_W = LOG2N + 1;
    localparam int TO_W  = $clog2(FFT_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(FFT_TIMEOUT - 1);

    // The dump is broken into sub-states so each byte has its own hold state
    // while tx_full is asserted.
    typedef enum logic [3:0] {
        S_IDLE,
        S_ACQ,
        S_FFT_START,
        S_FFT_WAIT,
        S_HDR0,     // push HDR_BYTE
        S_HDR1,     // push frame number
        S_RD,       // res_raddr presented, RAM access in progress
        S_LAT,      // res_rdata valid, capture word
        S_HI,       // push high byte
        S_LO        // push low byte, advance bin or finish frame
    } state_t;

    state_t r_state, w_next;

    logic                r_en_meta, r_en_s;
    logic [CNT_W-1:0]    r_cnt;         // samples captured; MSB set = frame full
    logic [TO_W-1:0]     r_to;
    logic [LOG2N-2:0]    r_raddr;       // doubles as the bin index
    logic [RES_W-1:0]    r_word;
    logic                r_buf_we;
    logic [LOG2N-1:0]    r_buf_waddr;
    logic [11:0]         r_buf_wdata;
    logic [7:0]          r_frame_cnt;
    logic                r_overrun, r_fft_err;

    logic w_capture, w_cnt_clr, w_to_clr, w_to_inc, w_err_set, w_ovr_set;
    logic w_raddr_clr, w_raddr_inc, w_latch, w_frame_done, w_busy;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge sysCLK or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // -------------------------------------------------------------------------
    // Next state and control
    // -------------------------------------------------------------------------
    always_comb begin
        w_next       = r_state;
        w_capture    = 1'b0;
        w_cnt_clr    = 1'b0;
        w_to_clr     = 1'b0;
        w_to_inc     = 1'b0;
        w_err_set    = 1'b0;
        w_raddr_clr  = 1'b0;
        w_raddr_inc  = 1'b0;
        w_latch      = 1'b0;
        w_frame_done = 1'b0;
        w_busy       = 1'b0;
        fft_start    = 1'b0;
        tx_wr        = 1'b0;
        tx_data      = 8'h00;

        unique case (r_state)
            S_IDLE: begin
                w_cnt_clr = 1'b1;
                if (r_en_s) w_next = S_ACQ;
            end

            S_ACQ: begin
                // Once full, hold here for the cycle in which the last
                // registered write lands, so the start pulse follows it.
                if (!r_en_s)              w_next = S_IDLE;
                else if (r_cnt[LOG2N])    w_next = S_FFT_START;
                else                      w_capture = data_valid;
            end

            S_FFT_START: begin
                w_busy    = 1'b1;
                fft_start = 1'b1;
                w_to_clr  = 1'b1;
                w_next    = S_FFT_WAIT;
            end

            S_FFT_WAIT: begin
                w_busy = 1'b1;
                // done is checked first so it wins over a same-cycle timeout
                if (fft_done) begin
                    w_raddr_clr = 1'b1;
                    w_next      = S_HDR0;
                end else if (r_to == TO_LAST) begin
                    w_err_set = 1'b1;
                    w_next    = S_IDLE;
                end else begin
                    w_to_inc = 1'b1;
                end
            end

            S_HDR0: begin
                w_busy  = 1'b1;
                tx_data = HDR_BYTE;
                tx_wr   = !tx_full;
                if (!tx_full) w_next = S_HDR1;
            end

            S_HDR1: begin
                w_busy  = 1'b1;
                tx_data = r_frame_cnt;
                tx_wr   = !tx_full;
                if (!tx_full) w_next = S_RD;
            end

            S_RD: begin
                w_busy = 1'b1;
                w_next = S_LAT;
            end

            S_LAT: begin
                w_busy  = 1'b1;
                w_latch = 1'b1;
                w_next  = S_HI;
            end

            S_HI: begin
                w_busy  = 1'b1;
                tx_data = r_word[RES_W-1 -: 8];
                tx_wr   = !tx_full;
                if (!tx_full) w_next = S_LO;
            end

            S_LO: begin
                w_busy  = 1'b1;
                tx_data = r_word[7:0];
                tx_wr   = !tx_full;
                if (!tx_full) begin
                    if (r_raddr == '1) begin
                        w_frame_done = 1'b1;
                        w_cnt_clr    = 1'b1;
                        w_next       = r_en_s ? S_ACQ : S_IDLE;
                    end else begin
                        w_raddr_inc = 1'b1;
                        w_next      = S_RD;
                    end
                end
            end

            default: w_next = S_IDLE;
        endcase

        w_ovr_set = w_busy && data_valid && r_en_s;
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge sysCLK or posedge rst) begin
        if (rst) begin
            r_en_meta   <= 1'b0;
            r_en_s      <= 1'b0;
            r_cnt       <= '0;
            r_to        <= '0;
            r_raddr     <= '0;
            r_word      <= '0;
            r_buf_we    <= 1'b0;
            r_buf_waddr <= '0;
            r_buf_wdata <= '0;
            r_frame_cnt <= '0;
            r_overrun   <= 1'b0;
            r_fft_err   <= 1'b0;
        end else begin
            r_en_meta <= enable_sw;
            r_en_s    <= r_en_meta;

            r_buf_we <= w_capture;
            if (w_capture) begin
                r_buf_waddr <= r_cnt[LOG2N-1:0];
                r_buf_wdata <= data;
            end

            if (w_cnt_clr)      r_cnt <= '0;
            else if (w_capture) r_cnt <= r_cnt + 1'b1;

            if (w_to_clr)      r_to <= '0;
            else if (w_to_inc) r_to <= r_to + 1'b1;

            if (w_raddr_clr)      r_raddr <= '0;
            else if (w_raddr_inc) r_raddr <= r_raddr + 1'b1;

            if (w_latch) r_word <= res_rdata;

            if (w_frame_done) r_frame_cnt <= r_frame_cnt + 8'd1;
            if (w_ovr_set)    r_overrun   <= 1'b1;
            if (w_err_set)    r_fft_err   <= 1'b1;
        end
    end

    assign buf_we    = r_buf_we;
    assign buf_waddr = r_buf_waddr;
    assign buf_wdata = r_buf_wdata;
    assign res_raddr = r_raddr;
    assign frame_cnt = r_frame_cnt;
    assign overrun   = r_overrun;
    assign fft_err   = r_fft_err;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
module tb_fft_frame_sequencer;
    localparam int N  = 16;
    localparam int LG = 4;
    localparam int TO = 100;

    logic        sysCLK = 1'b0;
    logic        rst = 1'b1;
    logic        enable_sw = 1'b0;
    logic [11:0] data = '0;
    logic        data_valid = 1'b0;
    logic        fft_done = 1'b0;
    logic [15:0] res_rdata = '0;
    logic        tx_full = 1'b0;
    logic        buf_we, fft_start, tx_wr, overrun, fft_err;
    logic [LG-1:0] buf_waddr;
    logic [11:0] buf_wdata;
    logic [LG-2:0] res_raddr;
    logic [7:0]  tx_data, frame_cnt;
    logic [39:0] outs;

    fft_frame_sequencer #(.N_FFT(N), .LOG2N(LG), .RES_W(16), .FFT_TIMEOUT(TO), .HDR_BYTE(8'hA5)) dut (
        .sysCLK(sysCLK), .rst(rst), .enable_sw(enable_sw), .data(data), .data_valid(data_valid),
        .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata), .fft_start(fft_start),
        .fft_done(fft_done), .res_raddr(res_raddr), .res_rdata(res_rdata), .tx_data(tx_data),
        .tx_wr(tx_wr), .tx_full(tx_full), .frame_cnt(frame_cnt), .overrun(overrun), .fft_err(fft_err)
    );

    assign outs = {buf_we, buf_waddr, buf_wdata, fft_start, res_raddr, tx_data, tx_wr, frame_cnt, overrun, fft_err};

    always #5 sysCLK = ~sysCLK;

    int cyc = 0;
    always @(posedge sysCLK) cyc <= cyc + 1;

    // result RAM model with one cycle read latency
    logic [15:0] ram [N/2];
    always @(posedge sysCLK) res_rdata <= ram[res_raddr];

    int          checks = 0, errors = 0;
    int          exp_wr[$];          // {addr, data} as addr*4096+data
    logic [7:0]  exp_tx[$];
    logic [7:0]  m_fc = 8'h00;       // model frame counter
    int          tx_acc = 0, n_start = 0, last_we = -10;
    int          bp_mode = 0;
    bit          hit_rst = 1'b0;

    function automatic void chk(input bit ok, input string nm, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    task automatic tick();
        @(posedge sysCLK);
        #1;
    endtask

    // monitor / scoreboard
    initial begin : mon
        int e;
        logic [7:0] b;
        forever begin
            @(negedge sysCLK);
            if (buf_we) begin
                if (exp_wr.size() == 0) chk(1'b0, "buf_wr_unexpected", int'({buf_waddr, buf_wdata}), 0);
                else begin
                    e = exp_wr.pop_front();
                    chk(int'({buf_waddr, buf_wdata}) == e, "buf_wr", int'({buf_waddr, buf_wdata}), e);
                end
                if (buf_waddr == 4'(N - 1)) last_we = cyc;
            end
            if (fft_start) begin
                n_start++;
                chk(cyc == last_we + 1, "start_after_last_write", cyc - last_we, 1);
            end
            if (tx_wr) begin
                chk(!tx_full, "wr_while_full", tx_full, 0);
                if (exp_tx.size() == 0) chk(1'b0, "tx_unexpected", tx_data, 0);
                else begin
                    b = exp_tx.pop_front();
                    chk(tx_data == b, "tx_byte", tx_data, b);
                end
                tx_acc++;
            end
        end
    end

    // TX FIFO backpressure: mode 1 = full for 10 cycles after every 3rd byte, mode 2 = random
    initial begin : bp
        int acc, hold;
        bit a;
        acc = 0; hold = 0;
        forever begin
            @(negedge sysCLK);
            a = tx_wr;
            @(posedge sysCLK);
            #1;
            if (a) acc++;
            if (bp_mode == 1 && a && acc % 3 == 0) hold = 10;
            if (bp_mode == 2) tx_full = ($urandom_range(0, 3) == 0);
            else if (hold > 0) begin tx_full = 1'b1; hold--; end
            else tx_full = 1'b0;
        end
    end

    // d = cycles from fft_start to fft_done (0 = never, expect timeout)
    task automatic frame(input bit ramp, input int d, input bit hold, input bit h12, input int rst_after);
        int s, acc0;
        logic [11:0] v;
        for (int i = 0; i < N; i++) begin
            if (!ramp && !hold) begin
                data_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            v = ramp ? 12'(i) : 12'($urandom_range(0, 4095));
            data = v; data_valid = 1'b1;
            exp_wr.push_back(i * 4096 + int'(v));
            tick();
        end
        if (hold) data = 12'($urandom_range(0, 4095));
        else data_valid = 1'b0;
        for (int i = 0; i < 20 && !fft_start; i++) tick();
        chk(fft_start == 1'b1, "start_seen", fft_start, 1);
        if (!fft_start) begin data_valid = 1'b0; return; end
        s = cyc;
        if (d == 0) begin
            for (int i = 0; i < 300 && !fft_err; i++) tick();
            chk(cyc == s + TO + 1, "timeout_latency", cyc - s, TO + 1);
            chk(fft_err == 1'b1, "fft_err_set", fft_err, 1);
            data_valid = 1'b0;
            repeat (2) tick();
            chk(frame_cnt == m_fc, "frame_cnt_after_timeout", frame_cnt, m_fc);
            return;
        end
        for (int k = 0; k < N / 2; k++) ram[k] = h12 ? 16'h1200 + 16'(k) : 16'($urandom_range(0, 65535));
        exp_tx.push_back(8'hA5);
        exp_tx.push_back(m_fc);
        for (int k = 0; k < N / 2; k++) begin
            exp_tx.push_back(ram[k][15:8]);
            exp_tx.push_back(ram[k][7:0]);
        end
        repeat (d) tick();
        fft_done = 1'b1; data_valid = 1'b0;
        tick();
        fft_done = 1'b0;
        acc0 = tx_acc;
        for (int i = 0; i < 3000; i++) begin
            if (exp_tx.size() == 0) break;
            if (rst_after > 0 && tx_acc - acc0 >= rst_after) begin hit_rst = 1'b1; return; end
            tick();
        end
        chk(exp_tx.size() == 0, "dump_complete", exp_tx.size(), 0);
        exp_tx.delete();
        m_fc = m_fc + 8'd1;
        repeat (2) tick();
        chk(frame_cnt == m_fc, "frame_cnt", frame_cnt, m_fc);
        chk(exp_wr.size() == 0, "writes_drained", exp_wr.size(), 0);
    endtask

    initial begin : wdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n0, nf;
        for (int k = 0; k < N / 2; k++) ram[k] = '0;
        rst = 1'b1;
        repeat (20) tick();
        chk(outs == 40'd0, "reset_outputs", longint'(outs), 0);
        rst = 1'b0;

        // idle: samples and stray done pulses must be ignored
        for (int i = 0; i < 10; i++) begin
            data = 12'($urandom_range(0, 4095)); data_valid = 1'b1;
            fft_done = (i == 4);
            tick();
        end
        data_valid = 1'b0; fft_done = 1'b0;
        tick();
        chk(overrun == 1'b0, "idle_no_overrun", overrun, 0);

        enable_sw = 1'b1;
        repeat (5) tick();
        frame(1'b1, 30, 1'b0, 1'b1, 0);                     // ramp + 0x1200+k
        frame(1'b0, $urandom_range(1, 40), 1'b0, 1'b0, 0);  // header frame number 01
        bp_mode = 1;
        frame(1'b0, $urandom_range(1, 40), 1'b0, 1'b0, 0);
        bp_mode = 0;
        repeat (12) tick();
        frame(1'b0, TO, 1'b0, 1'b0, 0);                     // done on the timeout cycle
        chk(fft_err == 1'b0, "done_wins_over_timeout", fft_err, 0);
        frame(1'b0, 0, 1'b0, 1'b0, 0);                      // timeout
        chk(overrun == 1'b0, "no_overrun_yet", overrun, 0);
        frame(1'b0, $urandom_range(5, 40), 1'b1, 1'b0, 0);  // valid held through FFT_WAIT
        chk(overrun == 1'b1, "overrun_set", overrun, 1);

        // abort partway through acquisition
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            data = 12'($urandom_range(0, 4095)); data_valid = 1'b1;
            exp_wr.push_back(i * 4096 + int'(data));
            tick();
        end
        data_valid = 1'b0; enable_sw = 1'b0;
        n0 = n_start;
        repeat (10) tick();
        chk(n_start == n0, "abort_no_start", n_start - n0, 0);
        chk(exp_wr.size() == 0, "abort_writes", exp_wr.size(), 0);
        enable_sw = 1'b1;
        repeat (5) tick();
        frame(1'b0, $urandom_range(1, 40), 1'b0, 1'b0, 0);

        bp_mode = 2;
        for (int f = 0; f < 20; f++) frame(1'b0, $urandom_range(1, 60), 1'b0, 1'b0, 0);
        bp_mode = 0;
        repeat (3) tick();
        chk(overrun == 1'b1, "overrun_sticky", overrun, 1);

        // run the frame counter through FF -> 00
        nf = 257 - int'(m_fc);
        for (int f = 0; f < nf; f++) frame(1'b0, 2, 1'b0, 1'b0, 0);

        // async reset in the middle of a dump
        frame(1'b0, 10, 1'b0, 1'b0, 5);
        chk(hit_rst == 1'b1, "reached_mid_dump", hit_rst, 1);
        #2 rst = 1'b1;
        #1 chk(outs == 40'd0, "async_reset_outputs", longint'(outs), 0);
        exp_tx.delete();
        exp_wr.delete();
        m_fc = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        chk({frame_cnt, overrun, fft_err} == 10'd0, "post_reset_state", {frame_cnt, overrun, fft_err}, 0);
        frame(1'b0, $urandom_range(1, 40), 1'b0, 1'b0, 0);

        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
